kb_ascii_decoder: RTL and testbench
===================================

KB_ASCII_DECODER -- requirements
Module: kb_ascii_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO depth in entries; power of 2, range 2..64.
REQ-002 Parameter PASS_UNMAPPED, default 0. When 1, unmapped make codes are queued as the raw scan byte; when 0, they are dropped.
REQ-003 The clock port SHALL be clk, 1 bit, input. All logic is on the rising edge.
REQ-004 The reset port SHALL be rst_n, 1 bit, input. Reset is synchronous and active-low, on the single clock clk.
REQ-005 scan_data, input, 8 bits: PS/2 set-2 scan byte.
REQ-006 scan_valid, input, 1 bit: scan_data is valid this cycle; single-cycle strobe with no backpressure.
REQ-007 ascii_data, output, 8 bits: FIFO head character; 0x00 when the FIFO is empty.
REQ-008 ascii_valid, output, 1 bit: FIFO is non-empty.
REQ-009 ascii_ready, input, 1 bit: consumer pops the head when ascii_valid && ascii_ready.
REQ-010 shift_state, output, 1 bit: left or right shift is held.
REQ-011 caps_state, output, 1 bit: caps lock is latched.
REQ-012 fifo_count, output, clog2(FIFO_DEPTH)+1 bits: number of occupied entries.
REQ-013 overflow, output, 1 bit: sticky flag indicating a character was lost to a full FIFO.

Function
REQ-014 Prefix FSM SHALL have states IDLE, BRK, EXT, EXT_BRK. Every transition occurs only on a scan_valid cycle.
REQ-015 Transitions:
- IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte is a make, stay IDLE.
- EXT: 0xF0 -> EXT_BRK; any other byte -> IDLE.
- BRK: any byte is a break, -> IDLE.
- EXT_BRK: any byte -> IDLE.
REQ-016 Shift tracking:
- Make of 0x12 or 0x59 sets that shift bit.
- Break of 0x12 or 0x59 clears it.
- shift_state is the OR of the two bits.
REQ-017 Make of 0x58 SHALL toggle caps_state; break of 0x58 has no effect.
REQ-018 Bytes completed in EXT or EXT_BRK SHALL NOT generate characters or change shift/caps state.
REQ-019 Letter mapping: letters a..z map to 0x41..0x5A when (shift XOR caps), else 0x61..0x7A.
REQ-020 Digit mapping: digits 0..9 map to 0x30..0x39, or to US-layout shifted symbols (e.g. 1 -> 0x21) when shift is held; caps has no effect.
REQ-021 Punctuation ` - = [ ] \ ; ' , . / SHALL map to its US-layout glyph, or to its shifted glyph when shift is held.
REQ-022 Control keys: space 0x29 -> 0x20; enter 0x5A -> 0x0D; backspace 0x66 -> 0x08; tab 0x0D -> 0x09; esc 0x76 -> 0x1B.
REQ-023 Modifier makes (0x12, 0x59, 0x58) SHALL NOT be queued.
REQ-024 Unmapped makes follow PASS_UNMAPPED.
REQ-025 Latency: a character from a make sampled at edge N is written to the FIFO at edge N. ascii_valid and fifo_count reflect it after edge N.
REQ-026 The shift/caps value used for a character is the value before the same-edge update.
REQ-027 Repeated makes with no intervening break (typematic) SHALL each queue a character.
REQ-028 FIFO order is first-in first-out. Read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 Full FIFO with a write and no pop: the write is dropped, overflow is set, and contents are unchanged.
REQ-030 Full FIFO with a simultaneous pop and write: both occur, and fifo_count stays FIFO_DEPTH with no overflow.
REQ-031 Empty FIFO with a simultaneous write and pop attempt: no pop occurs (ascii_valid was 0) and the write succeeds.
REQ-032 Pop on an empty FIFO SHALL be ignored.
REQ-033 overflow SHALL clear only on reset.

Reset
REQ-034 When rst_n=0 at a clock edge, the following SHALL result:
- FSM goes to IDLE.
- Shift bits, caps_state, overflow and fifo_count go to 0.
- Pointers go to 0.
- ascii_valid=0 and ascii_data=0x00.
REQ-035 Reset mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix. The next byte is then treated as a make in IDLE.
REQ-036 scan_valid and ascii_ready SHALL be ignored during reset cycles.

Verification
REQ-037 Bytes 1C, F0 1C -> one entry 0x61 ('a'), fifo_count=1, ascii_valid high the cycle after the 1C edge.
REQ-038 Bytes 12, 1C, 16, F0 12, 1C -> entries 0x41, 0x21, 0x61. shift_state=0 at the end.
REQ-039 Bytes 58, F0 58, 1C, 12, 1C -> caps_state=1; entries 0x41, 0x61 (shift XOR caps).
REQ-040 Bytes E0 12, E0 F0 12, 1C -> shift_state stays 0 throughout; single entry 0x61.
REQ-041 FIFO_DEPTH=8, ascii_ready=0, 9 makes of 0x29 -> fifo_count=8, overflow=1. Then hold ascii_ready=1 with a same-cycle make -> count stays 8, overflow stays 1, output order preserved.
REQ-042 Bytes 12, F0, then rst_n low for 1 cycle, then 1C -> shift_state=0, entry 0x61, fifo_count=1, overflow=0.

Source files
------------

// File: rtl/kb_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with shift/caps tracking and an output FIFO.
// Prefix FSM qualifies make/break events; characters are queued on the make edge.
module kb_ascii_decoder #(
   parameter int unsigned FIFO_DEPTH    = 8,
   parameter bit          PASS_UNMAPPED = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [7:0]                    scan_data,
   input  logic                          scan_valid,
   output logic [7:0]                    ascii_data,
   output logic                          ascii_valid,
   input  logic                          ascii_ready,
   output logic                          shift_state,
   output logic                          caps_state,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
   typedef enum logic [1:0] {K_NONE, K_LETTER, K_SYM} kind_t;

   state_t        state_q, state_d;
   logic          is_make, is_break;
   logic          lshift_q, lshift_d;
   logic          rshift_q, rshift_d;
   logic          caps_q, caps_d;
   logic          ovf_q, ovf_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   kind_t         kind_c;
   logic [7:0]    lo_c, hi_c, char_c;
   logic          modifier_c, push_req, push, pop, empty, full, shift_now;

   // ---------------- prefix FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      is_make  = 1'b0;
      is_break = 1'b0;
      if (scan_valid) begin
         unique case (state_q)
            IDLE: begin
               if (scan_data == 8'hE0)      state_d = EXT;
               else if (scan_data == 8'hF0) state_d = BRK;
               else                         is_make = 1'b1;
            end
            EXT:     state_d = (scan_data == 8'hF0) ? EXT_BRK : IDLE;
            BRK: begin
               is_break = 1'b1;
               state_d  = IDLE;
            end
            EXT_BRK: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // ---------------- modifiers ----------------
   always_comb begin
      lshift_d = lshift_q;
      rshift_d = rshift_q;
      caps_d   = caps_q;
      if (is_make) begin
         if (scan_data == 8'h12) lshift_d = 1'b1;
         if (scan_data == 8'h59) rshift_d = 1'b1;
         if (scan_data == 8'h58) caps_d   = ~caps_q;
      end
      if (is_break) begin
         if (scan_data == 8'h12) lshift_d = 1'b0;
         if (scan_data == 8'h59) rshift_d = 1'b0;
      end
   end

   assign shift_now  = lshift_q | rshift_q;
   assign modifier_c = (scan_data == 8'h12) || (scan_data == 8'h59) || (scan_data == 8'h58);

   // ---------------- key map: lo = unshifted glyph, hi = shifted glyph ----------------
   always_comb begin
      kind_c = K_SYM;
      lo_c   = '0;
      hi_c   = '0;
      unique case (scan_data)
         8'h1C: begin kind_c = K_LETTER; lo_c = 8'h61; end
         8'h32: begin kind_c = K_LETTER; lo_c = 8'h62; end
         8'h21: begin kind_c = K_LETTER; lo_c = 8'h63; end
         8'h23: begin kind_c = K_LETTER; lo_c = 8'h64; end
         8'h24: begin kind_c = K_LETTER; lo_c = 8'h65; end
         8'h2B: begin kind_c = K_LETTER; lo_c = 8'h66; end
         8'h34: begin kind_c = K_LETTER; lo_c = 8'h67; end
         8'h33: begin kind_c = K_LETTER; lo_c = 8'h68; end
         8'h43: begin kind_c = K_LETTER; lo_c = 8'h69; end
         8'h3B: begin kind_c = K_LETTER; lo_c = 8'h6A; end
         8'h42: begin kind_c = K_LETTER; lo_c = 8'h6B; end
         8'h4B: begin kind_c = K_LETTER; lo_c = 8'h6C; end
         8'h3A: begin kind_c = K_LETTER; lo_c = 8'h6D; end
         8'h31: begin kind_c = K_LETTER; lo_c = 8'h6E; end
         8'h44: begin kind_c = K_LETTER; lo_c = 8'h6F; end
         8'h4D: begin kind_c = K_LETTER; lo_c = 8'h70; end
         8'h15: begin kind_c = K_LETTER; lo_c = 8'h71; end
         8'h2D: begin kind_c = K_LETTER; lo_c = 8'h72; end
         8'h1B: begin kind_c = K_LETTER; lo_c = 8'h73; end
         8'h2C: begin kind_c = K_LETTER; lo_c = 8'h74; end
         8'h3C: begin kind_c = K_LETTER; lo_c = 8'h75; end
         8'h2A: begin kind_c = K_LETTER; lo_c = 8'h76; end
         8'h1D: begin kind_c = K_LETTER; lo_c = 8'h77; end
         8'h22: begin kind_c = K_LETTER; lo_c = 8'h78; end
         8'h35: begin kind_c = K_LETTER; lo_c = 8'h79; end
         8'h1A: begin kind_c = K_LETTER; lo_c = 8'h7A; end
         8'h45: begin lo_c = 8'h30; hi_c = 8'h29; end
         8'h16: begin lo_c = 8'h31; hi_c = 8'h21; end
         8'h1E: begin lo_c = 8'h32; hi_c = 8'h40; end
         8'h26: begin lo_c = 8'h33; hi_c = 8'h23; end
         8'h25: begin lo_c = 8'h34; hi_c = 8'h24; end
         8'h2E: begin lo_c = 8'h35; hi_c = 8'h25; end
         8'h36: begin lo_c = 8'h36; hi_c = 8'h5E; end
         8'h3D: begin lo_c = 8'h37; hi_c = 8'h26; end
         8'h3E: begin lo_c = 8'h38; hi_c = 8'h2A; end
         8'h46: begin lo_c = 8'h39; hi_c = 8'h28; end
         8'h0E: begin lo_c = 8'h60; hi_c = 8'h7E; end
         8'h4E: begin lo_c = 8'h2D; hi_c = 8'h5F; end
         8'h55: begin lo_c = 8'h3D; hi_c = 8'h2B; end
         8'h54: begin lo_c = 8'h5B; hi_c = 8'h7B; end
         8'h5B: begin lo_c = 8'h5D; hi_c = 8'h7D; end
         8'h5D: begin lo_c = 8'h5C; hi_c = 8'h7C; end
         8'h4C: begin lo_c = 8'h3B; hi_c = 8'h3A; end
         8'h52: begin lo_c = 8'h27; hi_c = 8'h22; end
         8'h41: begin lo_c = 8'h2C; hi_c = 8'h3C; end
         8'h49: begin lo_c = 8'h2E; hi_c = 8'h3E; end
         8'h4A: begin lo_c = 8'h2F; hi_c = 8'h3F; end
         8'h29: begin lo_c = 8'h20; hi_c = 8'h20; end
         8'h5A: begin lo_c = 8'h0D; hi_c = 8'h0D; end
         8'h66: begin lo_c = 8'h08; hi_c = 8'h08; end
         8'h0D: begin lo_c = 8'h09; hi_c = 8'h09; end
         8'h76: begin lo_c = 8'h1B; hi_c = 8'h1B; end
         default: kind_c = K_NONE;
      endcase
   end

   // Pre-update shift/caps registers select the glyph for this edge's make.
   always_comb begin
      char_c = scan_data;
      unique case (kind_c)
         K_LETTER: char_c = (shift_now ^ caps_q) ? (lo_c & 8'hDF) : lo_c;
         K_SYM:    char_c = shift_now ? hi_c : lo_c;
         default:  char_c = scan_data;
      endcase
   end

   assign push_req = is_make && !modifier_c && ((kind_c != K_NONE) || PASS_UNMAPPED);

   // ---------------- output FIFO ----------------
   assign empty = (count_q == '0);
   assign full  = (count_q == DEPTH_C);
   assign pop   = !empty && ascii_ready;
   assign push  = push_req && (!full || pop);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      ovf_d    = ovf_q | (push_req && full && !pop);
      count_d  = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lshift_q <= 1'b0;
         rshift_q <= 1'b0;
         caps_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         lshift_q <= lshift_d;
         rshift_q <= rshift_d;
         caps_q   <= caps_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push) mem_q[wr_ptr_q] <= char_c;
   end

   assign ascii_data  = empty ? '0 : mem_q[rd_ptr_q];
   assign ascii_valid = !empty;
   assign shift_state = shift_now;
   assign caps_state  = caps_q;
   assign fifo_count  = count_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_kb_ascii_decoder.sv
// Scoreboard bench for kb_ascii_decoder: stimulus pushes expected characters,
// a negedge monitor pops and compares whenever the DUT pops a character.
module tb_kb_ascii_decoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] scan_data;
   logic       scan_valid;
   logic [7:0] ascii_data;
   logic       ascii_valid;
   logic       ascii_ready;
   logic       shift_state;
   logic       caps_state;
   logic [3:0] fifo_count;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] exp_q[$];

   kb_ascii_decoder #(.FIFO_DEPTH(8), .PASS_UNMAPPED(1'b0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_data   (scan_data),
      .scan_valid  (scan_valid),
      .ascii_data  (ascii_data),
      .ascii_valid (ascii_valid),
      .ascii_ready (ascii_ready),
      .shift_state (shift_state),
      .caps_state  (caps_state),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next posedge whenever valid && ready here.
   always @(negedge clk) begin
      if (rst_n && ascii_valid && ascii_ready) begin
         if (exp_q.size() == 0) chk("unexpected_char", {24'h0, ascii_data}, 32'hFFFF_FFFF);
         else                   chk("char", {24'h0, ascii_data}, {24'h0, exp_q.pop_front()});
      end
   end

   // Called at posedge+1; returns at posedge+1 after the byte's sampling edge.
   task automatic send(input logic [7:0] b);
      scan_data  = b;
      scan_valid = 1'b1;
      @(posedge clk); #1;
      scan_valid = 1'b0;
   endtask

   task automatic sendx(input logic [7:0] b, input logic [7:0] e);
      exp_q.push_back(e);
      send(b);
   endtask

   task automatic drain();
      ascii_ready = 1'b1;
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_left", exp_q.size(), 0);
      chk("drain_count", {28'h0, fifo_count}, 0);
      chk("drain_valid", {31'h0, ascii_valid}, 0);
      chk("empty_data", {24'h0, ascii_data}, 0);
      @(posedge clk); #1;
      chk("pop_empty_count", {28'h0, fifo_count}, 0);
      ascii_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; scan_data = '0; scan_valid = 1'b0; ascii_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_valid", {31'h0, ascii_valid}, 0);
      chk("rst_data", {24'h0, ascii_data}, 0);
      chk("rst_count", {28'h0, fifo_count}, 0);
      chk("rst_shift", {31'h0, shift_state}, 0);
      chk("rst_caps", {31'h0, caps_state}, 0);
      chk("rst_ovf", {31'h0, overflow}, 0);

      // Single make then break of 'a'
      sendx(8'h1C, 8'h61);
      chk("a_valid", {31'h0, ascii_valid}, 1);
      chk("a_count", {28'h0, fifo_count}, 1);
      chk("a_head", {24'h0, ascii_data}, 8'h61);
      send(8'hF0); send(8'h1C);
      chk("a_count_end", {28'h0, fifo_count}, 1);
      drain();

      // Left shift letter/digit, then release
      send(8'h12);
      chk("lshift_on", {31'h0, shift_state}, 1);
      sendx(8'h1C, 8'h41);
      sendx(8'h16, 8'h21);
      send(8'hF0); send(8'h12);
      chk("lshift_off", {31'h0, shift_state}, 0);
      sendx(8'h1C, 8'h61);
      chk("shift_count", {28'h0, fifo_count}, 3);
      drain();

      // Caps lock XOR shift
      send(8'h58); send(8'hF0); send(8'h58);
      chk("caps_on", {31'h0, caps_state}, 1);
      sendx(8'h1C, 8'h41);
      send(8'h12);
      sendx(8'h1C, 8'h61);
      send(8'hF0); send(8'h12);
      chk("caps_count", {28'h0, fifo_count}, 2);
      drain();
      send(8'h58); send(8'hF0); send(8'h58);
      chk("caps_off", {31'h0, caps_state}, 0);

      // Extended codes ignored
      send(8'hE0); send(8'h12);
      chk("ext_shift", {31'h0, shift_state}, 0);
      send(8'hE0); send(8'hF0); send(8'h12);
      chk("extbrk_shift", {31'h0, shift_state}, 0);
      send(8'hE0); send(8'h1C);
      sendx(8'h1C, 8'h61);
      chk("ext_count", {28'h0, fifo_count}, 1);
      drain();

      // Streaming with ready held: write into empty FIFO with pop attempt
      ascii_ready = 1'b1;
      sendx(8'h29, 8'h20);
      chk("empty_wr_pop", {28'h0, fifo_count}, 1);
      send(8'h12);
      sendx(8'h45, 8'h29); sendx(8'h4E, 8'h5F); sendx(8'h4A, 8'h3F);
      sendx(8'h0E, 8'h7E); sendx(8'h1E, 8'h40); sendx(8'h36, 8'h5E);
      send(8'hF0); send(8'h12);
      sendx(8'h4E, 8'h2D); sendx(8'h52, 8'h27); sendx(8'h5D, 8'h5C);
      sendx(8'h1E, 8'h32); sendx(8'h54, 8'h5B); sendx(8'h5B, 8'h5D);
      send(8'h59);
      chk("rshift_on", {31'h0, shift_state}, 1);
      sendx(8'h15, 8'h51); sendx(8'h4C, 8'h3A);
      send(8'hF0); send(8'h59);
      sendx(8'h15, 8'h71); sendx(8'h4C, 8'h3B);
      sendx(8'h5A, 8'h0D); sendx(8'h66, 8'h08); sendx(8'h0D, 8'h09); sendx(8'h76, 8'h1B);
      sendx(8'h1A, 8'h7A); sendx(8'h1A, 8'h7A);
      send(8'h05);
      send(8'h58);
      sendx(8'h1A, 8'h5A);
      send(8'h12);
      sendx(8'h21, 8'h63); sendx(8'h16, 8'h21);
      send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);
      drain();

      // Overflow: 9 spaces into depth 8, then an extra dropped 'q'
      for (int i = 0; i < 9; i++) begin
         if (i < 8) exp_q.push_back(8'h20);
         send(8'h29);
      end
      chk("full_count", {28'h0, fifo_count}, 8);
      chk("ovf_set", {31'h0, overflow}, 1);
      send(8'h15);
      chk("full_drop_count", {28'h0, fifo_count}, 8);
      ascii_ready = 1'b1;
      sendx(8'h1C, 8'h61);
      chk("full_wr_pop_count", {28'h0, fifo_count}, 8);
      chk("ovf_sticky", {31'h0, overflow}, 1);
      drain();
      chk("ovf_after_drain", {31'h0, overflow}, 1);

      // Reset mid-prefix discards pending break; inputs ignored during reset
      send(8'h12);
      chk("pre_rst_shift", {31'h0, shift_state}, 1);
      send(8'hF0);
      rst_n = 1'b0; scan_data = 8'h29; scan_valid = 1'b1; ascii_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; scan_valid = 1'b0; ascii_ready = 1'b0;
      chk("rst2_count", {28'h0, fifo_count}, 0);
      chk("rst2_ovf", {31'h0, overflow}, 0);
      chk("rst2_shift", {31'h0, shift_state}, 0);
      sendx(8'h1C, 8'h61);
      chk("rst2_a_count", {28'h0, fifo_count}, 1);
      chk("rst2_a_head", {24'h0, ascii_data}, 8'h61);
      chk("rst2_a_shift", {31'h0, shift_state}, 0);
      drain();

      chk("leftover", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
